ififo_loader: RTL and testbench
===============================

// Module: ififo_loader
// PURPOSE
//  Upstream feeder for the input-FIFO bank (col x depth-16 FIFOs). On start, reads num_rows
//  consecutive words from activation/weight SRAM (1-cycle read latency) and pushes each word,
//  split into col lanes of bw bits, into all FIFO columns with a uniform write strobe.
//  Lanes outside col_mask are zero-filled so columns stay row-aligned.
//  A 2-entry skid buffer absorbs SRAM latency against FIFO back-pressure.
//  Sustained rate: one row/cycle.
// PARAMETERS
//  col     8   FIFO columns / lanes per SRAM word
//  bw      4   bits per lane
//  addr_w  11  SRAM address width
//  cnt_w   11  width of num_rows and internal row counters
// PORTS
//  clk        in   1          single clock, posedge
//  reset      in   1          synchronous, active-low
//  start      in   1          1-cycle request; sampled only in IDLE
//  base_addr  in   addr_w     first SRAM address; latched on accepted start
//  num_rows   in   cnt_w      rows to transfer; latched on accepted start
//  col_mask   in   col        1 = lane carries SRAM data, 0 = lane forced to 0; latched on start
//  sram_cen   out  1          SRAM chip enable, active-low
//  sram_wen   out  1          SRAM write enable, active-low; tied 1 (read-only)
//  sram_addr  out  addr_w     SRAM read address
//  sram_dout  in   col*bw     SRAM read data, valid the cycle after cen=0
//  fifo_in    out  col*bw     lane i = bits [i*bw +: bw]
//  fifo_wr    out  col        per-column write strobe; always all-ones or all-zeros
//  fifo_ready in   1          FIFO bank reports no column full
//  busy       out  1          high from accepted start until done
//  done       out  1          1-cycle pulse after the last FIFO write
// BEHAVIOUR
//  Reset (reset==0 at posedge)
//   - state=IDLE; sram_cen=1, sram_addr=0, fifo_in=0, fifo_wr=0, busy=0, done=0.
//   - Skid buffer, in-flight flag and counters cleared.
//   - Reset mid-transfer abandons the transfer: no done pulse, data dropped.
//  FSM
//   - IDLE -> RUN on start with num_rows!=0 (latch inputs; busy=1 next cycle).
//   - IDLE -> DONE on start with num_rows==0 (no SRAM access, no write).
//   - RUN: issue reads until rd_cnt==num_rows.
//   - RUN -> DRAIN when the last read issues.
//   - DRAIN -> DONE when wr_cnt==num_rows.
//   - DONE: done=1, busy=0 for one cycle, then -> IDLE.
//   - start outside IDLE is ignored.
//  Read issue (RUN only)
//   - occ = skid_count + inflight.
//   - sram_cen=0 when rd_cnt<num_rows and (occ<2 or (occ==2 and fifo write this cycle)).
//   - sram_addr = base_addr + rd_cnt, wraps mod 2^addr_w.
//   - Issued read sets inflight. Data is pushed into the skid on the next posedge.
//  FIFO write
//   - fifo_wr = {col{skid_nonempty & fifo_ready}}: combinational on fifo_ready.
//   - fifo_in = skid head, registered, with masked lanes zeroed.
//   - Head pops on write; wr_cnt increments.
//   - fifo_ready=0 holds fifo_in stable and fifo_wr=0. No data loss, no duplicates.
//   - Simultaneous push and pop with skid full: both allowed, count unchanged.
//  Latency
//   - start@c0 -> first sram_cen=0@c1 -> first fifo_wr@c3 (if fifo_ready).
//   - Last write@cN -> done@cN+1.
//  Widths
//   - Counters are cnt_w bits.
//   - num_rows = 2^cnt_w - 1 is legal; num_rows == 0 is handled above.
// STRUCTURE
//  - Shared package ece284_pkg: col, bw, addr_w defaults; loader_state_t enum
//    {IDLE, RUN, DRAIN, DONE}.
//  - Sub-module skid_buf2 #(.w(col*bw)): 2-entry FIFO with push, pop, head, count.
//  - Remaining logic: FSM, counters, issue logic.
// TESTING
//  1. base=0x010, rows=4, mask=8'hFF, ready=1, SRAM[i]=i*0x11111111
//     -> cen=0 c1..c4 at addr 0x010..0x013; fifo_wr=8'hFF c3..c6; fifo_in 0x..0,1,2,3 pattern;
//     done@c7.
//  2. rows=6, ready drops low for cycles 4-7
//     -> at most 2 reads in flight while stalled; fifo_in frozen; exactly 6 writes in order;
//     done one cycle after the 6th write.
//  3. mask=8'h0F, SRAM word 0xABCD1234
//     -> fifo_in=0x00001234, fifo_wr=8'hFF.
//  4. rows=0
//     -> done@c1, busy never high, cen never low, fifo_wr never high.
//  5. base=0x7FE, rows=3 -> addresses 0x7FE, 0x7FF, 0x000.
//     Second start mid-run is ignored -> exactly 3 writes.
//  6. reset=0 asserted mid-RUN after 2 writes
//     -> next cycle all outputs 0 / cen=1, no done pulse.
//     A new start then runs cleanly from base_addr.

Source files
------------

// File: rtl/ece284_pkg.sv
// ----------------------------------------------------------------------------
// ece284_pkg
// Shared defaults and types for the input-FIFO loader.
//   col_def    : FIFO columns / lanes per SRAM word
//   bw_def     : bits per lane
//   addr_w_def : SRAM address width
//   cnt_w_def  : row counter width
//   loader_state_t : loader control states
// ----------------------------------------------------------------------------
package ece284_pkg;

    localparam int col_def    = 8;
    localparam int bw_def     = 4;
    localparam int addr_w_def = 11;
    localparam int cnt_w_def  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/skid_buf2.sv
// ----------------------------------------------------------------------------
// skid_buf2
// Two-entry first-in/first-out holding buffer. Entry 0 is always the head.
// Ports:
//   clk, reset : clock and synchronous active-low reset (clears storage)
//   push, din  : write request and data
//   pop        : remove the head entry
//   head       : oldest entry (stale when count == 0)
//   count      : number of valid entries (0..2)
// A push and a pop in the same cycle are both honoured, including when full.
// ----------------------------------------------------------------------------
module skid_buf2 #(
    parameter int w = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [w-1:0] din,
    input  logic         pop,
    output logic [w-1:0] head,
    output logic [1:0]   count
);

    logic [w-1:0] ent0_reg;
    logic [w-1:0] ent1_reg;
    logic [1:0]   count_reg;
    logic         pop_ok;
    logic         push_ok;

    // Pops of an empty buffer and pushes into a full buffer without a
    // simultaneous pop are dropped so the count can never wrap.
    assign pop_ok  = pop && (count_reg != 2'd0);
    assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ent0_reg  <= '0;
            ent1_reg  <= '0;
            count_reg <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_reg == 2'd0) begin
                        ent0_reg <= din;
                    end else begin
                        ent1_reg <= din;
                    end
                    count_reg <= count_reg + 2'd1;
                end
                2'b01: begin
                    ent0_reg  <= ent1_reg;
                    count_reg <= count_reg - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new word lands behind whatever
                    // remains after the head leaves.
                    if (count_reg == 2'd1) begin
                        ent0_reg <= din;
                    end else begin
                        ent0_reg <= ent1_reg;
                        ent1_reg <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = ent0_reg;
    assign count = count_reg;

endmodule

// File: rtl/ififo_loader.sv
// ----------------------------------------------------------------------------
// ififo_loader
// Feeds the input-FIFO bank: on start, reads num_rows consecutive SRAM words
// (1-cycle read latency) and writes each one, split into col lanes of bw
// bits, into all FIFO columns at once. Lanes cleared in col_mask are written
// as zero. A 2-entry skid buffer decouples SRAM latency from FIFO
// back-pressure while sustaining one row per cycle.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   start               : 1-cycle request, honoured only when idle
//   base_addr, num_rows, col_mask : transfer parameters, latched on start
//   sram_cen, sram_wen  : SRAM controls (active-low; wen tied high)
//   sram_addr           : SRAM read address
//   sram_dout           : SRAM read data, valid the cycle after cen=0
//   fifo_in, fifo_wr    : FIFO lane data and uniform per-column strobe
//   fifo_ready          : FIFO bank can accept a row this cycle
//   busy, done          : transfer in progress / 1-cycle completion pulse
// ----------------------------------------------------------------------------
module ififo_loader
    import ece284_pkg::*;
#(
    parameter int col    = col_def,
    parameter int bw     = bw_def,
    parameter int addr_w = addr_w_def,
    parameter int cnt_w  = cnt_w_def
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addr_w-1:0]   base_addr,
    input  logic [cnt_w-1:0]    num_rows,
    input  logic [col-1:0]      col_mask,
    output logic                sram_cen,
    output logic                sram_wen,
    output logic [addr_w-1:0]   sram_addr,
    input  logic [col*bw-1:0]   sram_dout,
    output logic [col*bw-1:0]   fifo_in,
    output logic [col-1:0]      fifo_wr,
    input  logic                fifo_ready,
    output logic                busy,
    output logic                done
);

    loader_state_t      state_reg;
    loader_state_t      state_next;
    logic [addr_w-1:0]  base_reg;
    logic [cnt_w-1:0]   rows_reg;
    logic [col-1:0]     mask_reg;
    logic [cnt_w-1:0]   rd_cnt_reg;
    logic [cnt_w-1:0]   wr_cnt_reg;
    logic               inflight_reg;

    logic [col*bw-1:0]  skid_head;
    logic [1:0]         skid_count;
    logic [1:0]         occ;
    logic               wr;
    logic               issue;
    logic               accept;

    skid_buf2 #(
        .w (col*bw)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_reg),
        .din   (sram_dout),
        .pop   (wr),
        .head  (skid_head),
        .count (skid_count)
    );

    // Slots already committed: words held plus the word arriving this cycle.
    assign occ = skid_count + {1'b0, inflight_reg};

    assign wr     = (skid_count != 2'd0) && fifo_ready;
    assign accept = (state_reg == IDLE) && start;

    // A third outstanding word is only allowed if a slot frees this cycle,
    // which keeps occupancy at or below the skid depth at all times.
    assign issue = (state_reg == RUN) && (rd_cnt_reg < rows_reg) &&
                   ((occ < 2'd2) || ((occ == 2'd2) && wr));

    assign sram_cen  = !issue;
    assign sram_wen  = 1'b1;
    assign sram_addr = base_reg + addr_w'(rd_cnt_reg);

    assign fifo_wr = {col{wr}};
    assign busy    = (state_reg == RUN) || (state_reg == DRAIN);
    assign done    = (state_reg == DONE);

    for (genvar gi = 0; gi < col; gi++) begin : g_lane
        assign fifo_in[gi*bw +: bw] = mask_reg[gi] ? skid_head[gi*bw +: bw] : '0;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (num_rows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue && ((rd_cnt_reg + cnt_w'(1)) == rows_reg)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Look at the write happening now so done follows the last
                // write by exactly one cycle.
                if (wr && ((wr_cnt_reg + cnt_w'(1)) == rows_reg)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            rows_reg     <= '0;
            mask_reg     <= '0;
            rd_cnt_reg   <= '0;
            wr_cnt_reg   <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= issue;
            if (accept) begin
                base_reg   <= base_addr;
                rows_reg   <= num_rows;
                mask_reg   <= col_mask;
                rd_cnt_reg <= '0;
                wr_cnt_reg <= '0;
            end else begin
                if (issue) begin
                    rd_cnt_reg <= rd_cnt_reg + cnt_w'(1);
                end
                if (wr) begin
                    wr_cnt_reg <= wr_cnt_reg + cnt_w'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ififo_loader.sv
// ----------------------------------------------------------------------------
// tb_ififo_loader
// Directed bench for ififo_loader with an SRAM model and a scoreboard of
// expected FIFO rows filled when each transfer is started.
// ----------------------------------------------------------------------------
module tb_ififo_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] base_addr;
    logic [10:0] num_rows;
    logic [7:0]  col_mask;
    logic        sram_cen;
    logic        sram_wen;
    logic [10:0] sram_addr;
    logic [31:0] sram_dout;
    logic [31:0] fifo_in;
    logic [7:0]  fifo_wr;
    logic        fifo_ready;
    logic        busy;
    logic        done;

    logic [31:0] sram_mem [2048];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] exp_q [$];
    int          issued = 0;
    int          writes = 0;
    int          rows_cur = 0;
    logic [10:0] base_cur = '0;
    logic        busy_exp = 1'b0;
    logic        done_due = 1'b0;
    int          cyc_rel = 0;
    int          first_cen = -1;
    int          first_wr = -1;
    int          last_wr = -1;
    int          done_cyc = -1;
    int          done_cnt = 0;
    logic        done_seen = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_in = '0;
    logic [31:0] last_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_cen === 1'b0) begin
            sram_dout <= sram_mem[sram_addr];
        end
    end

    ififo_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .col_mask   (col_mask),
        .sram_cen   (sram_cen),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_dout  (sram_dout),
        .fifo_in    (fifo_in),
        .fifo_wr    (fifo_wr),
        .fifo_ready (fifo_ready),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [31:0] mask_word(input logic [31:0] w, input logic [7:0] m);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 8; i++) begin
            if (!m[i]) r[i*4 +: 4] = 4'h0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs shortly after the edge, sample and
    // check outputs a little later, then advance the reference model.
    task automatic cycle(input logic st, input logic rdy, input logic rst);
        logic        cur_busy;
        logic        cur_done;
        logic        wrote;
        logic [10:0] exp_addr;
        logic [10:0] a;
        logic [31:0] exp_word;
        @(posedge clk);
        #1;
        start      = st;
        fifo_ready = rdy;
        reset      = rst;
        #1;
        cyc_rel++;
        cur_busy = busy_exp;
        cur_done = done_due;
        wrote    = 1'b0;

        chk("done", {31'b0, done}, {31'b0, cur_done});
        chk("busy", {31'b0, busy}, {31'b0, cur_busy});
        chk("wen", {31'b0, sram_wen}, 32'd1);
        if (done === 1'b1) begin
            done_seen = 1'b1;
            done_cyc  = cyc_rel;
            done_cnt++;
        end
        if (sram_cen === 1'b0) begin
            exp_addr = base_cur + 11'(issued);
            chk("rd_range", {31'b0, issued < rows_cur}, 32'd1);
            chk("addr", {21'b0, sram_addr}, {21'b0, exp_addr});
            if (issued == 0) first_cen = cyc_rel;
            issued++;
        end
        if (fifo_wr !== 8'h00) begin
            wrote = 1'b1;
            chk("wr_all", {24'b0, fifo_wr}, 32'h0000_00FF);
            chk("wr_ready", {31'b0, fifo_ready}, 32'd1);
            chk("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                exp_word = exp_q.pop_front();
                chk("data", fifo_in, exp_word);
            end
            last_data = fifo_in;
            if (writes == 0) first_wr = cyc_rel;
            writes++;
            last_wr = cyc_rel;
        end
        chk("occ", {31'b0, (issued - writes) <= 2}, 32'd1);
        if (!fifo_ready && prev_stall && writes > 0) begin
            chk("frozen", fifo_in, prev_in);
        end
        prev_stall = !fifo_ready;
        prev_in    = fifo_in;

        done_due = wrote && (writes == rows_cur) && (rows_cur != 0);
        if (done_due) busy_exp = 1'b0;
        if (st && rst && !cur_busy && !cur_done) begin
            base_cur  = base_addr;
            rows_cur  = int'(num_rows);
            issued    = 0;
            writes    = 0;
            cyc_rel   = 0;
            first_cen = -1;
            first_wr  = -1;
            last_wr   = -1;
            done_cyc  = -1;
            done_cnt  = 0;
            done_seen = 1'b0;
            for (int i = 0; i < int'(num_rows); i++) begin
                a = base_addr + 11'(i);
                exp_q.push_back(mask_word(sram_mem[a], col_mask));
            end
            if (num_rows == '0) done_due = 1'b1;
            else busy_exp = 1'b1;
        end
        if (!rst) begin
            exp_q.delete();
            busy_exp = 1'b0;
            done_due = 1'b0;
            issued   = 0;
            writes   = 0;
            rows_cur = 0;
        end
    endtask

    task automatic launch(input logic [10:0] b, input logic [10:0] r, input logic [7:0] m);
        base_addr = b;
        num_rows  = r;
        col_mask  = m;
        cycle(1'b1, 1'b1, 1'b1);
    endtask

    task automatic run_until_done(input logic stall, input int budget);
        int n;
        for (int k = 0; k < budget && !done_seen; k++) begin
            n = cyc_rel + 1;
            cycle(1'b0, !(stall && n >= 4 && n <= 7), 1'b1);
        end
        chk("done_seen", {31'b0, done_seen}, 32'd1);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        fifo_ready = 1'b1;
        base_addr  = '0;
        num_rows   = '0;
        col_mask   = '0;
        for (int i = 0; i < 2048; i++) sram_mem[i] = $urandom;
        for (int i = 0; i < 4; i++) sram_mem[16 + i] = i * 32'h1111_1111;
        sram_mem[11'h100] = 32'hABCD_1234;

        // Power-up reset state
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        chk("rst_cen", {31'b0, sram_cen}, 32'd1);
        chk("rst_addr", {21'b0, sram_addr}, 32'd0);
        chk("rst_fifo_in", fifo_in, 32'd0);
        chk("rst_fifo_wr", {24'b0, fifo_wr}, 32'd0);

        // 1: basic 4-row transfer, latency checks
        launch(11'h010, 11'd4, 8'hFF);
        run_until_done(1'b0, 40);
        chk("t1_first_cen", first_cen, 32'd1);
        chk("t1_first_wr", first_wr, 32'd3);
        chk("t1_last_wr", last_wr, 32'd6);
        chk("t1_done_cyc", done_cyc, 32'd7);
        chk("t1_writes", writes, 32'd4);
        cycle(1'b0, 1'b1, 1'b1);

        // 2: back-pressure during cycles 4-7
        launch(11'h020, 11'd6, 8'hFF);
        run_until_done(1'b1, 60);
        chk("t2_writes", writes, 32'd6);
        chk("t2_done_after_last", done_cyc, last_wr + 1);
        cycle(1'b0, 1'b1, 1'b1);

        // 3: lane masking
        launch(11'h100, 11'd1, 8'h0F);
        run_until_done(1'b0, 40);
        chk("t3_data", last_data, 32'h0000_1234);
        cycle(1'b0, 1'b1, 1'b1);

        // 4: zero-row request
        launch(11'h050, 11'd0, 8'hFF);
        run_until_done(1'b0, 10);
        chk("t4_done_cyc", done_cyc, 32'd1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1);
        chk("t4_writes", writes, 32'd0);

        // 5: address wrap and ignored second start
        launch(11'h7FE, 11'd3, 8'hFF);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        base_addr = 11'h000;
        num_rows  = 11'd5;
        cycle(1'b1, 1'b1, 1'b1);
        run_until_done(1'b0, 40);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b1);
        chk("t5_writes", writes, 32'd3);
        chk("t5_done_cnt", done_cnt, 32'd1);

        // 6: reset mid-transfer, then a clean restart
        launch(11'h200, 11'd8, 8'hFF);
        for (int k = 0; k < 30 && writes < 2; k++) cycle(1'b0, 1'b1, 1'b1);
        chk("t6_two_writes", writes, 32'd2);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        chk("t6_cen", {31'b0, sram_cen}, 32'd1);
        chk("t6_addr", {21'b0, sram_addr}, 32'd0);
        chk("t6_fifo_in", fifo_in, 32'd0);
        chk("t6_fifo_wr", {24'b0, fifo_wr}, 32'd0);
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b1);
        chk("t6_no_done", done_cnt, 32'd0);
        launch(11'h300, 11'd3, 8'hFF);
        run_until_done(1'b0, 40);
        chk("t6_restart_writes", writes, 32'd3);
        chk("t6_restart_first_cen", first_cen, 32'd1);
        cycle(1'b0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
